uart_tx_fifo: RTL

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_tx_fifo_if.sv | 17 +
 rtl/uart_tx_fifo.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus of the UART transmit FIFO: enqueue strobe/data plus occupancy status.
interface uart_tx_fifo_if #(
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [DATA_BITS-1:0] wr_data;
    logic                 wr_en_n;
    logic                 full;
    logic                 empty;
    logic [LW-1:0]        level;
    logic                 overflow;

    modport master (output wr_data, wr_en_n, input full, empty, level, overflow);
    modport slave  (input wr_data, wr_en_n, output full, empty, level, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a DEPTH-entry FIFO; frames go out back-to-back while data is queued.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | line high, waiting for a queued byte
// S_START  | start bit (0) for CLK_DIV cycles
// S_DATA   | data bits LSB first, one per CLK_DIV cycles
// S_PARITY | parity bit, only visited when PARITY != 0
// S_STOP   | STOP_BITS stop bits (1); pops the next byte on the last cycle
module uart_tx_fifo #(
    parameter int CLK_DIV   = 434,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic          clk,
    input  logic          res_n,
    uart_tx_fifo_if.slave wr,
    output logic          busy,
    output logic          uart_tx
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LOAD  = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_ONE   = LW'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [2:0]    DATA_LAST = 3'(DATA_BITS - 1);
    localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t state, state_next;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [AW-1:0]        wr_ptr, rd_ptr;
    logic [LW-1:0]        count;
    logic                 overflow_q;
    logic [CW-1:0]        bit_cnt;
    logic [2:0]           bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] head;
    logic                 par_bit;
    logic                 push, drop, pop, bit_done;
    logic                 cnt_load, idx_inc, idx_clr, tx_next;

    assign wr.full     = (count == LVL_FULL);
    assign wr.empty    = (count == '0);
    assign wr.level    = count;
    assign wr.overflow = overflow_q;

    assign push     = ~wr.wr_en_n & ~wr.full;
    assign drop     = ~wr.wr_en_n &  wr.full;
    assign bit_done = (bit_cnt == '0);
    assign busy     = (state != S_IDLE);
    assign head     = mem[rd_ptr];

    // Storage is deliberately left unreset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wr.wr_data;
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= drop;
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + LVL_ONE;
                2'b01:   count <= count - LVL_ONE;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            par_bit <= 1'b0;
            uart_tx <= 1'b1;
        end else begin
            state   <= state_next;
            uart_tx <= tx_next;
            if (cnt_load)       bit_cnt <= CNT_LOAD;
            else if (!bit_done) bit_cnt <= bit_cnt - CNT_ONE;
            if (idx_clr)        bit_idx <= '0;
            else if (idx_inc)   bit_idx <= bit_idx + 3'd1;
            if (pop) begin
                shreg   <= head;
                par_bit <= (^head) ^ PAR_ODD;
            end else if (state == S_DATA && bit_done) begin
                shreg <= shreg >> 1;
            end
        end
    end

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        cnt_load   = 1'b0;
        idx_inc    = 1'b0;
        idx_clr    = 1'b0;
        tx_next    = 1'b1;
        case (state)
            S_IDLE: begin
                if (!wr.empty) begin
                    pop        = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    cnt_load   = 1'b1;
                    idx_clr    = 1'b1;
                    state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    cnt_load = 1'b1;
                    if (bit_idx == DATA_LAST) begin
                        idx_clr    = 1'b1;
                        state_next = (PARITY != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (bit_done) begin
                    cnt_load   = 1'b1;
                    idx_clr    = 1'b1;
                    state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    if (bit_idx == STOP_LAST) begin
                        idx_clr = 1'b1;
                        // Chain straight into the next start bit when more data waits.
                        if (!wr.empty) begin
                            pop        = 1'b1;
                            cnt_load   = 1'b1;
                            state_next = S_START;
                        end else begin
                            state_next = S_IDLE;
                        end
                    end else begin
                        cnt_load = 1'b1;
                        idx_inc  = 1'b1;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
        // Line output is registered, so it trails the state by one cycle.
        case (state)
            S_START:  tx_next = 1'b0;
            S_DATA:   tx_next = shreg[0];
            S_PARITY: tx_next = par_bit;
            default:  tx_next = 1'b1;
        endcase
    end
endmodule
